mem_responder: RTL and testbench

- Synchronous memory target on the CPU's data/instruction bus; answers the CPU's req/ack load/store handshake.
- Holds a DEPTH-word RAM and returns read data or commits write data after a fixed, parameterised latency.
- Sits beside cpu in the top level and in cpu-level benches, replacing ad-hoc behavioural memory.
- Flags out-of-range accesses with an error response instead of aliasing.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU load/store bus between a requester (master) and a memory target (slave).
// req/we/addr/wdata are held stable by the master until it sees ack.
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// DEPTH-word memory target answering the CPU req/ack handshake after LATENCY cycles.
// Stores commit and loads are read at the capture edge; out-of-range accesses return err.
module mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [0:(1<<IDX_W)-1];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rdata_hold;
    logic              err_pend;
    logic              capture;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Unsigned compare one bit wider than addr so DEPTH == 2**ADDR_W is representable.
    assign capture  = (state == IDLE) && bus.req;
    assign in_range = ({1'b0, bus.addr} < DEPTH_L);
    assign idx      = bus.addr[IDX_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.ack   = (state == RESP);
        bus.err   = (state == RESP) && err_pend;
        bus.busy  = (state != IDLE);
        bus.rdata = (state == RESP) ? rd_q : rdata_hold;
    end

    // RAM is never cleared; a store committed at its capture edge survives a later reset.
    always_ff @(posedge clk) begin
        if (capture && !reset && bus.we && in_range) begin
            mem[idx] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q       <= '0;
            err_pend   <= 1'b0;
            rdata_hold <= '0;
        end else begin
            if (capture) begin
                rd_q     <= (in_range && !bus.we) ? mem[idx] : '0;
                err_pend <= !in_range;
            end
            if (state == RESP) begin
                rdata_hold <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance share clock and reset.
// Expected responses are queued when a request is issued and popped when ack appears.
module tb_mem_responder;

    logic clk;
    logic reset;

    mem_responder_if #(.DATA_W(32), .ADDR_W(8)) b2 ();
    mem_responder_if #(.DATA_W(32), .ADDR_W(8)) b1 ();

    mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .LATENCY(2)) u2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .LATENCY(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed;
    int   total;

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [7:0] a, input logic [31:0] d);
        if (sel) begin
            b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d;
        end else begin
            b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
        end
    endtask

    task automatic sample(input bit sel, output logic a, output logic [31:0] r,
                          output logic e, output logic b);
        if (sel) begin
            a = b1.ack; r = b1.rdata; e = b1.err; b = b1.busy;
        end else begin
            a = b2.ack; r = b2.rdata; e = b2.err; b = b2.busy;
        end
    endtask

    // Issue one request at the current negedge, wait (bounded) for ack, pop the expectation.
    task automatic run_txn(input bit sel, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           input logic exp_err, output int lat,
                           output logic [31:0] rd, output logic er, output exp_t ex);
        logic ak, bz;
        drive(sel, 1'b1, w, a, d);
        sb.push_back('{exp_rd, exp_err});
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            sample(sel, ak, rd, er, bz);
            if (ak === 1'b1) begin
                lat = i;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 8'd0, 32'd0);
        ex = sb.pop_front();
    endtask

    task automatic test_reset();
        logic ak, er, bz;
        logic [31:0] rd;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 8'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s[0], ak, rd, er, bz);
            total++;
            if ({ak, er, bz, rd} !== 35'd0)
                $display("FAIL reset_outputs dut%0d: ack=%b err=%b busy=%b rdata=%h, want all 0", s, ak, er, bz, rd);
            else passed++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sample(0, ak, rd, er, bz);
            total++;
            if ({ak, er, bz, rd} !== 35'd0)
                $display("FAIL idle_static cycle %0d: ack=%b err=%b busy=%b rdata=%h, want all 0", c, ak, er, bz, rd);
            else passed++;
        end
    endtask

    task automatic test_store_load();
        int lat;
        logic [31:0] rd;
        logic er, ak, bz;
        exp_t ex;
        @(negedge clk);
        run_txn(0, 1'b1, 8'd5, 32'hDEADBEEF, 32'h0, 1'b0, lat, rd, er, ex);
        total++;
        if (lat !== 2) $display("FAIL store_latency: got %0d, want 2", lat); else passed++;
        total++;
        if (rd !== ex.rd || er !== ex.err)
            $display("FAIL store_resp: rdata=%h err=%b, want rdata=%h err=%b", rd, er, ex.rd, ex.err);
        else passed++;
        @(negedge clk);
        sample(0, ak, rd, er, bz);
        total++;
        if (ak !== 1'b0 || bz !== 1'b0)
            $display("FAIL store_ack_one_cycle: ack=%b busy=%b, want 0 0", ak, bz);
        else passed++;
        run_txn(0, 1'b0, 8'd5, 32'd0, 32'hDEADBEEF, 1'b0, lat, rd, er, ex);
        total++;
        if (lat !== 2) $display("FAIL load_latency: got %0d, want 2", lat); else passed++;
        total++;
        if (rd !== ex.rd || er !== ex.err)
            $display("FAIL load_resp: rdata=%h err=%b, want rdata=%h err=%b", rd, er, ex.rd, ex.err);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic ak, er, bz;
        logic [31:0] rd;
        exp_t ex;
        int acks;
        int pos[$];
        acks = 0;
        drive(0, 1'b1, 1'b0, 8'd5, 32'd0);
        for (int k = 0; k < 3; k++) sb.push_back('{32'hDEADBEEF, 1'b0});
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            sample(0, ak, rd, er, bz);
            if (ak === 1'b1) begin
                acks++;
                pos.push_back(c);
                if (sb.size() > 0) begin
                    ex = sb.pop_front();
                    total++;
                    if (rd !== ex.rd || er !== ex.err)
                        $display("FAIL b2b_resp cycle %0d: rdata=%h err=%b, want %h %b", c, rd, er, ex.rd, ex.err);
                    else passed++;
                end
            end
            if (c == 3) begin
                total++;
                if (ak !== 1'b0 || bz !== 1'b0 || rd !== 32'hDEADBEEF)
                    $display("FAIL b2b_gap: ack=%b busy=%b rdata=%h, want 0 0 deadbeef", ak, bz, rd);
                else passed++;
            end
            if (c == 9) drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
        end
        total++;
        if (acks !== 3) $display("FAIL b2b_ack_count: got %0d, want 3", acks); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pos.size() <= k) $display("FAIL b2b_ack_pos %0d: missing, want cycle %0d", k, 2 + 3 * k);
            else if (pos[k] !== 2 + 3 * k)
                $display("FAIL b2b_ack_pos %0d: got cycle %0d, want %0d", k, pos[k], 2 + 3 * k);
            else passed++;
        end
        sb.delete();
        @(negedge clk);
        sample(0, ak, rd, er, bz);
        total++;
        if (bz !== 1'b0 || ak !== 1'b0)
            $display("FAIL b2b_release: busy=%b ack=%b, want 0 0", bz, ak);
        else passed++;
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [31:0] rd;
        logic er;
        exp_t ex;
        logic [7:0]  a_t [6] = '{8'd63, 8'd0, 8'd64, 8'd64, 8'd63, 8'd0};
        logic        w_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] d_t [6] = '{32'hCAFE0063, 32'h11110000, 32'h1234, 32'h0, 32'h0, 32'h0};
        logic [31:0] r_t [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE0063, 32'h11110000};
        logic        e_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            run_txn(0, w_t[i], a_t[i], d_t[i], r_t[i], e_t[i], lat, rd, er, ex);
            total++;
            if (lat !== 2 || rd !== ex.rd || er !== ex.err)
                $display("FAIL oor_txn%0d addr=%0d we=%b: lat=%0d rdata=%h err=%b, want 2 %h %b",
                         i, a_t[i], w_t[i], lat, rd, er, ex.rd, ex.err);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic ak, er, bz, saw;
        logic [31:0] rd;
        int lat;
        exp_t ex;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'd5, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        sample(0, ak, rd, er, bz);
        total++;
        if (bz !== 1'b0 || ak !== 1'b0 || rd !== 32'd0)
            $display("FAIL midreset_immediate: busy=%b ack=%b rdata=%h, want 0 0 0", bz, ak, rd);
        else passed++;
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sample(0, ak, rd, er, bz);
            if (ak !== 1'b0) saw = 1'b1;
        end
        reset = 1'b0;
        total++;
        if (saw !== 1'b0) $display("FAIL midreset_no_ack: ack seen=%b, want 0", saw); else passed++;
        @(negedge clk);
        run_txn(0, 1'b0, 8'd5, 32'd0, 32'hDEADBEEF, 1'b0, lat, rd, er, ex);
        total++;
        if (lat !== 2 || rd !== ex.rd || er !== ex.err)
            $display("FAIL midreset_reload: lat=%0d rdata=%h err=%b, want 2 %h %b", lat, rd, er, ex.rd, ex.err);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_latency1();
        logic ak, er, bz;
        logic [31:0] rd;
        int lat;
        exp_t ex;
        @(negedge clk);
        sample(1, ak, rd, er, bz);
        total++;
        if (bz !== 1'b0) $display("FAIL lat1_busy_before: got %b, want 0", bz); else passed++;
        run_txn(1, 1'b1, 8'd0, 32'h000000A5, 32'h0, 1'b0, lat, rd, er, ex);
        total++;
        if (lat !== 1 || rd !== ex.rd || er !== ex.err)
            $display("FAIL lat1_store: lat=%0d rdata=%h err=%b, want 1 %h %b", lat, rd, er, ex.rd, ex.err);
        else passed++;
        @(negedge clk);
        run_txn(1, 1'b0, 8'd0, 32'd0, 32'h000000A5, 1'b0, lat, rd, er, ex);
        total++;
        if (lat !== 1 || rd !== ex.rd || er !== ex.err)
            $display("FAIL lat1_load: lat=%0d rdata=%h err=%b, want 1 %h %b", lat, rd, er, ex.rd, ex.err);
        else passed++;
        sample(1, ak, rd, er, bz);
        total++;
        if (bz !== 1'b1) $display("FAIL lat1_busy_during: got %b, want 1", bz); else passed++;
        @(negedge clk);
        sample(1, ak, rd, er, bz);
        total++;
        if (bz !== 1'b0 || ak !== 1'b0)
            $display("FAIL lat1_busy_after: busy=%b ack=%b, want 0 0", bz, ak);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 8'd0, 32'd0);
        test_reset();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_latency1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
